// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parity-mode constants and parity helper for
// the UART line receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int unsigned UART_PAR_NONE = 0;
    localparam int unsigned UART_PAR_ODD  = 1;
    localparam int unsigned UART_PAR_EVEN = 2;

    // Expected parity bit over up to 9 data bits; unused upper bits must be 0.
    function automatic logic uart_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO for received characters.
//   clk, reset    : clock, synchronous active-high reset
//   push_i/wdata_i: write request and data (dropped when full unless popping)
//   pop_i         : remove head entry (ignored when empty)
//   rdata_o       : head entry (registered storage)
//   full_o/empty_o: occupancy flags
//   count_o       : current number of entries
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A write into a full FIFO is accepted when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: oversampling UART receiver with character FIFO and
// end-of-line tagging.
//   clk, reset       : clock, synchronous active-high reset
//   ser_rx           : asynchronous serial input, idles high
//   rx_data, rx_eol  : FIFO head character and its terminator flag
//   rx_valid/rx_ready: stream handshake, pop on rx_valid & rx_ready
//   frame_err        : one-cycle pulse on a low stop bit
//   parity_err       : one-cycle pulse on a parity mismatch
//   overflow, err_clr: sticky dropped-character flag and its clear
//   finished         : idle, FIFO empty and no unterminated line pending
module uart_line_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter logic [7:0]  TERM_CHAR    = 8'h0A,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ser_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_eol,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow,
    input  logic                 err_clr,
    output logic                 finished
);

    import uart_pkg::*;

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = 4;
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0]  TERM9 = {1'b0, TERM_CHAR};
    localparam logic [DATA_BITS-1:0] TERM_W = TERM9[DATA_BITS-1:0];

    logic                 sync_q, rx_s_q;
    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overflow_q, overflow_d;
    logic                 line_open_q, line_open_d;
    logic                 finished_q, finished_d;

    logic                 bit_end;
    logic                 push_w;
    logic                 eol_w;
    logic                 pop_w;
    logic                 accept_w;
    logic                 empty_next;
    logic                 fifo_full, fifo_empty;
    logic [FCW-1:0]       fifo_count;
    logic [DATA_BITS:0]   fifo_head;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign eol_w   = (shift_q == TERM_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= ser_rx;
            rx_s_q <= sync_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            line_open_q  <= 1'b0;
            finished_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            line_open_q  <= line_open_d;
            finished_q   <= finished_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_BREAK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: stop-bit verdict, FIFO write and status flags.
    always_comb begin
        push_w       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (state_q == ST_STOP && bit_end) begin
            if (!rx_s_q) begin
                frame_err_d = 1'b1;
            end else if ((PARITY != UART_PAR_NONE) &&
                         (par_q != uart_parity(9'(shift_q), PARITY == UART_PAR_ODD))) begin
                parity_err_d = 1'b1;
            end else begin
                push_w = 1'b1;
            end
        end

        pop_w    = !fifo_empty && rx_ready;
        accept_w = push_w && (!fifo_full || pop_w);

        // Set has priority over err_clr.
        overflow_d  = (push_w && !accept_w) ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        line_open_d = accept_w ? !eol_w : line_open_q;

        // finished is registered, so it is built from next-cycle occupancy.
        empty_next = accept_w ? 1'b0
                   : (fifo_empty || (pop_w && fifo_count == FCW'(1)));
        finished_d = (state_d == ST_IDLE) && empty_next && !line_open_d;
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_w),
        .wdata_i ({eol_w, shift_q}),
        .pop_i   (pop_w),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rx_data    = fifo_head[DATA_BITS-1:0];
    assign rx_eol     = fifo_head[DATA_BITS];
    assign rx_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: scoreboard bench for uart_line_rx. Instance A: no parity,
// 2-entry FIFO. Instance B: even parity, 8-entry FIFO.
module tb_uart_line_rx;

    localparam int CPB   = 4;
    localparam int LAT_A = 1 + CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_a = 1'b1, ser_b = 1'b1;
    logic       rx_ready_a = 1'b1, rx_ready_b = 1'b1;
    logic       err_clr_a = 1'b0, err_clr_b = 1'b0;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_eol_a, rx_eol_b, rx_valid_a, rx_valid_b;
    logic       frame_err_a, frame_err_b, parity_err_a, parity_err_b;
    logic       overflow_a, overflow_b, finished_a, finished_b;

    int tests = 0, failed = 0;
    int fe_cnt_a = 0, pe_cnt_a = 0, fe_cnt_b = 0, pe_cnt_b = 0;
    int exp_fe_a = 0, exp_fe_b = 0, exp_pe_b = 0;
    logic exp_ovf_a = 1'b0, exp_ovf_b = 1'b0;
    bit rand_ready = 1'b0;
    logic [8:0] q_a[$], q_b[$];
    logic [8:0] e_a, e_b;
    int lat;

    uart_line_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                   .TERM_CHAR(8'h0A), .FIFO_DEPTH(2)) u_a (
        .clk(clk), .reset(reset), .ser_rx(ser_a),
        .rx_data(rx_data_a), .rx_eol(rx_eol_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .overflow(overflow_a), .err_clr(err_clr_a), .finished(finished_a));

    uart_line_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                   .TERM_CHAR(8'h0A), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .reset(reset), .ser_rx(ser_b),
        .rx_data(rx_data_b), .rx_eol(rx_eol_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .overflow(overflow_b), .err_clr(err_clr_b), .finished(finished_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) ser_a = v;
        else            ser_b = v;
    endtask

    // Reference model: a good frame yields {eol, data} if the FIFO has room,
    // else an overflow; a low stop bit yields a frame error; a wrong parity
    // bit (instance B) yields a parity error.
    task automatic send_char(input int which, input logic [7:0] d, input bit par_ok,
                             input bit stop_ok, input int gap);
        if (!stop_ok) begin
            if (which == 0) exp_fe_a++;
            else            exp_fe_b++;
        end else if (which == 1 && !par_ok) begin
            exp_pe_b++;
        end else if (which == 0) begin
            if (q_a.size() < 2) q_a.push_back({d == 8'h0A, d});
            else                exp_ovf_a = 1'b1;
        end else begin
            if (q_b.size() < 8) q_b.push_back({d == 8'h0A, d});
            else                exp_ovf_b = 1'b1;
        end
        drive(which, 1'b0);
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            repeat (CPB) tick();
        end
        if (which == 1) begin
            drive(which, (^d) ^ !par_ok);
            repeat (CPB) tick();
        end
        drive(which, stop_ok);
        repeat (CPB) tick();
        drive(which, 1'b1);
        repeat (gap) tick();
    endtask

    task automatic wait_drain(input int which);
        int n = 0;
        while (n < 200 && ((which == 0) ? (q_a.size() != 0 || rx_valid_a)
                                        : (q_b.size() != 0 || rx_valid_b))) begin
            tick();
            n++;
        end
        if (which == 0) begin
            check("A drained rx_valid", rx_valid_a, 0);
            check("A pending expected chars", q_a.size(), 0);
        end else begin
            check("B drained rx_valid", rx_valid_b, 0);
            check("B pending expected chars", q_b.size(), 0);
        end
    endtask

    // Monitors: pop expected entries whenever the DUT hands one over.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err_a)  fe_cnt_a++;
            if (parity_err_a) pe_cnt_a++;
            if (rx_valid_a && rx_ready_a) begin
                if (q_a.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL A pop: got char %0h, expected no character", rx_data_a);
                end else begin
                    e_a = q_a.pop_front();
                    check("A pop data", rx_data_a, e_a[7:0]);
                    check("A pop eol", rx_eol_a, e_a[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err_b)  fe_cnt_b++;
            if (parity_err_b) pe_cnt_b++;
            if (rx_valid_b && rx_ready_b) begin
                if (q_b.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL B pop: got char %0h, expected no character", rx_data_b);
                end else begin
                    e_b = q_b.pop_front();
                    check("B pop data", rx_data_b, e_b[7:0]);
                    check("B pop eol", rx_eol_b, e_b[8]);
                end
            end
        end
    end

    initial begin
        forever begin
            tick();
            rx_ready_b = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        repeat (3) tick();
        check("reset A rx_valid", rx_valid_a, 0);
        check("reset A rx_data", rx_data_a, 0);
        check("reset A rx_eol", rx_eol_a, 0);
        check("reset A frame_err", frame_err_a, 0);
        check("reset A parity_err", parity_err_a, 0);
        check("reset A overflow", overflow_a, 0);
        check("reset A finished", finished_a, 1);
        check("reset B rx_valid", rx_valid_b, 0);
        check("reset B finished", finished_b, 1);
        reset = 1'b0;
        repeat (5) tick();

        // "Hi\n", back-to-back frames.
        check("A finished before line", finished_a, 1);
        fork
            send_char(0, 8'h48, 1'b1, 1'b1, 0);
            begin
                repeat (3*CPB) tick();
                check("A finished during first frame", finished_a, 0);
            end
        join
        send_char(0, 8'h69, 1'b1, 1'b1, 2*CPB);
        check("A finished with open line", finished_a, 0);
        send_char(0, 8'h0A, 1'b1, 1'b1, CPB);
        wait_drain(0);
        check("A finished after terminator", finished_a, 1);

        // One-cycle low glitch while idle.
        ser_a = 1'b0;
        tick();
        ser_a = 1'b1;
        repeat (3*CPB) tick();
        check("A glitch no push", rx_valid_a, 0);
        check("A glitch no frame_err", fe_cnt_a, exp_fe_a);
        check("A glitch finished", finished_a, 1);

        // Long break: a single frame error, then a clean character.
        exp_fe_a++;
        ser_a = 1'b0;
        repeat (20*CPB) tick();
        ser_a = 1'b1;
        repeat (2*CPB) tick();
        check("A break frame_err count", fe_cnt_a, exp_fe_a);
        send_char(0, 8'h41, 1'b1, 1'b1, CPB);
        wait_drain(0);
        check("A after break frame_err count", fe_cnt_a, exp_fe_a);

        // Start-bit to FIFO-write latency.
        rx_ready_a = 1'b0;
        lat = -1;
        fork
            send_char(0, 8'h3C, 1'b1, 1'b1, CPB);
            begin
                for (int n = 1; n <= 80; n++) begin
                    tick();
                    if (rx_valid_a === 1'b1) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        tests++;
        if (lat < LAT_A + 1 || lat > LAT_A + 2) begin
            failed++;
            $display("FAIL A latency: got %0d cycles, expected %0d..%0d", lat, LAT_A + 1, LAT_A + 2);
        end
        rx_ready_a = 1'b1;
        wait_drain(0);

        // Overflow with a 2-entry FIFO and a stalled consumer.
        rx_ready_a = 1'b0;
        send_char(0, 8'h41, 1'b1, 1'b1, CPB);
        send_char(0, 8'h42, 1'b1, 1'b1, CPB);
        send_char(0, 8'h43, 1'b1, 1'b1, CPB);
        check("A overflow set", overflow_a, exp_ovf_a);
        rx_ready_a = 1'b1;
        wait_drain(0);
        check("A overflow sticky", overflow_a, exp_ovf_a);
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
        exp_ovf_a = 1'b0;
        check("A overflow cleared", overflow_a, exp_ovf_a);

        // Reset in the middle of a data bit with a character buffered.
        rx_ready_a = 1'b0;
        send_char(0, 8'h33, 1'b1, 1'b1, CPB);
        check("A buffered before reset", rx_valid_a, 1);
        drive(0, 1'b0); repeat (CPB) tick();
        drive(0, 1'b1); repeat (CPB) tick();
        drive(0, 1'b0); repeat (CPB) tick();
        drive(0, 1'b1); repeat (CPB/2) tick();
        reset = 1'b1;
        tick();
        tick();
        q_a.delete();
        check("midreset A rx_valid", rx_valid_a, 0);
        check("midreset A rx_data", rx_data_a, 0);
        check("midreset A rx_eol", rx_eol_a, 0);
        check("midreset A frame_err", frame_err_a, 0);
        check("midreset A overflow", overflow_a, 0);
        check("midreset A finished", finished_a, 1);
        ser_a = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        repeat (4*CPB) tick();
        check("A no frame_err after reset", fe_cnt_a, exp_fe_a);
        rx_ready_a = 1'b1;
        send_char(0, 8'h5A, 1'b1, 1'b1, CPB);
        wait_drain(0);

        // Even parity on instance B.
        send_char(1, 8'h55, 1'b0, 1'b1, CPB);
        check("B parity_err count", pe_cnt_b, exp_pe_b);
        check("B bad parity no push", rx_valid_b, 0);
        send_char(1, 8'h55, 1'b1, 1'b1, CPB);
        wait_drain(1);
        check("B parity_err after good", pe_cnt_b, exp_pe_b);

        // Randomised frames with random consumer stalls.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_char(1, 8'($urandom), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 5) != 0, $urandom_range(1, 3) * CPB);
            check("B rand frame_err count", fe_cnt_b, exp_fe_b);
            check("B rand parity_err count", pe_cnt_b, exp_pe_b);
        end
        rand_ready = 1'b0;
        repeat (2) tick();
        wait_drain(1);
        check("B overflow", overflow_b, exp_ovf_b);
        check("A parity_err never", pe_cnt_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Parametrised, synthesizable UART receiver that replaces the free-running behavioural line printer in the test benches with a clocked block. It oversamples the serial line, checks start, parity and stop bits, and buffers characters in an internal FIFO behind a valid/ready stream. The character equal to the configured terminator is flagged with an end-of-line tag. It sits between a chip's `ser_tx` pin and bench or on-chip consumers that need received text line by line.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit; even, ≥4.
- `DATA_BITS`, 8: data bits per character, 5–9, LSB first.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `TERM_CHAR`, 8'h0A: terminator; compared on the low `DATA_BITS` bits.
- `FIFO_DEPTH`, 8: entries, power of two, ≥2.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ser_rx` in 1: asynchronous serial input; idles high.
- `rx_data` out `DATA_BITS`: FIFO head character.
- `rx_eol` out 1: head character equals `TERM_CHAR`.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid & rx_ready`.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `parity_err` out 1: one-cycle pulse on a parity mismatch.
- `overflow` out 1: sticky; a character was dropped because the FIFO was full.
- `err_clr` in 1: clears `overflow`.
- `finished` out 1: high when the receiver is IDLE, the FIFO is empty, and no unterminated line is pending.

## Operation
- `ser_rx` passes through a 2-flop synchronizer into `rx_s`. The synchronizer resets to 1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: if `rx_s`=0, go to START and set `cnt`=0.
  - START: `cnt` counts up. At `cnt`=`CLKS_PER_BIT`/2−1, sample `rx_s`. If 0, go to DATA with `cnt`=0 and `bit`=0. If 1, treat it as a glitch and go to IDLE with no error.
  - DATA: at `cnt`=`CLKS_PER_BIT`−1, shift in `rx_s` LSB first and set `cnt`=0. After bit `DATA_BITS`−1, go to PARITY if `PARITY`≠0, otherwise go to STOP.
  - PARITY: at `cnt`=`CLKS_PER_BIT`−1, sample `rx_s` and compute the expected parity bit over the data. Odd parity means data XOR parity bit = 1. Go to STOP.
  - STOP: at `cnt`=`CLKS_PER_BIT`−1, sample `rx_s`.
    - If 0: pulse `frame_err`, discard the character, and go to BREAK.
    - If 1 with a parity mismatch: pulse `parity_err`, discard the character, and go to IDLE.
    - Otherwise: write {eol, data} to the FIFO on this edge and go to IDLE.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A long low line generates exactly one `frame_err`.
- FIFO write when full: the character is dropped and `overflow` is set. If a pop happens on the same edge, the write is accepted instead and `overflow` is unchanged.
- `err_clr` and an overflow event on the same edge: the set wins.
- Line tracking: `line_open` sets on any accepted non-terminator character and clears on an accepted terminator.

## Timing
- All outputs are registered.
- Values during and after `reset`:
  - `rx_valid`, `frame_err`, `parity_err`, `overflow` = 0.
  - `finished` = 1.
  - `rx_data` and `rx_eol` = 0.
- Reset mid-frame aborts the frame, empties the FIFO, and returns to IDLE with no error pulse.
- `ser_rx` falling edge to first IDLE cycle seeing `rx_s`=0: 2–3 cycles.
- First IDLE cycle seeing `rx_s`=0 to FIFO write edge: 1 + `CLKS_PER_BIT`/2 + (`DATA_BITS` + P + 1)·`CLKS_PER_BIT` cycles, where P = (`PARITY`≠0).
- `rx_valid` rises on the FIFO write edge when the FIFO was empty.
- Error pulses fire on the STOP sample edge.
- Pop: `rx_data`, `rx_eol` and `rx_valid` update on the edge where `rx_valid & rx_ready`. Full throughput is one pop per cycle.
- Leaving STOP at mid-stop-bit tolerates ±4% baud mismatch and back-to-back frames.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - parity constants `UART_PAR_NONE`/`ODD`/`EVEN`;
  - a `uart_parity()` function.
- Sub-module `uart_rx_fifo`: synchronous FIFO with width `DATA_BITS`+1 and depth `FIFO_DEPTH`, providing full/empty and simultaneous push/pop.
- The top level contains the synchronizer, the FSM, `cnt`/`bit` counters, the shift register and the error/line logic.

## Test plan
- Defaults with `CLKS_PER_BIT`=4: send "Hi\n" with `rx_ready`=1.
  - Expect three pops: 8'h48 (eol=0), 8'h69 (eol=0), 8'h0A (eol=1).
  - Expect `finished` to fall after the first start bit and return to 1 after the last pop.
- `PARITY`=2: send 8'h55 with parity bit 1.
  - Expect one `parity_err` pulse and no push.
  - Then send 8'h55 with parity bit 0 and expect 8'h55 popped.
- Hold `ser_rx` low for 20 bit times, then release and send 8'h41.
  - Expect exactly one `frame_err` pulse, followed by a pop of 8'h41.
- `FIFO_DEPTH`=2, `rx_ready`=0: send 3 characters (A, B, C).
  - Expect `overflow`=1 and pops of A, B only.
  - Pulse `err_clr` and expect `overflow`=0.
- A 1-cycle low glitch on `ser_rx` while IDLE: no push and no error.
- Assert `reset` mid-DATA: all outputs go to reset values, and a subsequent clean 8'h5A is received correctly.
